irq_pend_arbiter: RTL and testbench

- Upstream feeder for the 4-bit lowest-index priority encoder.
- Converts level request lines into sticky pending events and applies a per-source mask.
- Selects the lowest-index pending, unmasked source and presents its index on a valid/ready interface.
- Clears the served pending bit on handshake.

---
 rtl/irq_pkg.sv | 21 ++
 rtl/lowest_set_enc.sv | 30 +++
 rtl/irq_pend_arbiter.sv | 124 ++++++++++++
 tb/tb_irq_pend_arbiter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : irq_pkg
// Description : Shared types and defaults for the pending-interrupt arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package irq_pkg;

    localparam int N_SRC_DEF = 4;
    localparam int IDX_W_DEF = $clog2(N_SRC_DEF);

    typedef logic [N_SRC_DEF-1:0] src_vec_t;
    typedef logic [IDX_W_DEF-1:0] src_idx_t;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/lowest_set_enc.sv
`default_nettype none
// ============================================================================
// Module      : lowest_set_enc
// Description : Lowest-index set-bit encoder; all-zero input yields index 0.
// Revision    : 1.0 - initial release
// ============================================================================
module lowest_set_enc
    import irq_pkg::*;
#(
    parameter int N_SRC = N_SRC_DEF,
    localparam int IDX_W = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] in_vec,
    output logic [IDX_W-1:0] sel,
    output logic             any_set
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        sel     = '0;
        any_set = |in_vec;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (in_vec[i]) begin
                sel = IDX_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/irq_pend_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : irq_pend_arbiter
// Description : Sticky pending-event capture, per-source mask and
//               lowest-index selection presented on a valid/ready port.
//               Optional macro IRQ_PEND_OVERFLOW_EN adds ovf / ovf_clr.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_pend_arbiter
    import irq_pkg::*;
#(
    parameter int N_SRC = N_SRC_DEF,
    localparam int IDX_W = $clog2(N_SRC)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] req,
    input  logic             mask_wr,
    input  logic [N_SRC-1:0] mask_wdata,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    input  logic             out_ready,
`ifdef IRQ_PEND_OVERFLOW_EN
    output logic [N_SRC-1:0] ovf,
    input  logic [N_SRC-1:0] ovf_clr,
`endif
    output logic [N_SRC-1:0] pend
);

    localparam logic [N_SRC-1:0] c_one = {{(N_SRC-1){1'b0}}, 1'b1};

    logic [N_SRC-1:0] r_req_q;
    logic [N_SRC-1:0] r_pending;
    logic [N_SRC-1:0] r_mask;
    logic [IDX_W-1:0] r_out_idx;
    arb_state_e       r_state;

    logic [N_SRC-1:0] w_rise;
    logic [N_SRC-1:0] w_clr;
    logic [N_SRC-1:0] w_eligible;
    logic [IDX_W-1:0] w_sel;
    logic             w_any;
    arb_state_e       w_state_nxt;
    logic [IDX_W-1:0] w_out_idx_nxt;

    assign w_rise     = req & ~r_req_q;
    assign w_clr      = (out_valid && out_ready) ? (c_one << r_out_idx) : '0;
    assign w_eligible = r_pending & ~r_mask;

    assign out_valid = (r_state == PRESENT);
    assign out_idx   = r_out_idx;
    assign pend      = r_pending;

    lowest_set_enc #(
        .N_SRC (N_SRC)
    ) u_enc (
        .in_vec  (w_eligible),
        .sel     (w_sel),
        .any_set (w_any)
    );

    // A new rise on the bit being served survives the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_req_q   <= '0;
            r_pending <= '0;
            r_mask    <= '0;
        end else begin
            r_req_q   <= req;
            r_pending <= (r_pending & ~w_clr) | w_rise;
            if (mask_wr) begin
                r_mask <= mask_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_out_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_out_idx <= w_out_idx_nxt;
        end
    end

    // Once presented, the index is held until accepted, even if masked.
    always_comb begin
        w_state_nxt   = r_state;
        w_out_idx_nxt = r_out_idx;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt   = PRESENT;
                    w_out_idx_nxt = w_sel;
                end
            end
            PRESENT: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

`ifdef IRQ_PEND_OVERFLOW_EN
    logic [N_SRC-1:0] r_ovf;
    logic [N_SRC-1:0] w_ovf_set;

    assign w_ovf_set = w_rise & r_pending & ~w_clr;
    assign ovf       = r_ovf;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= '0;
        end else begin
            r_ovf <= (r_ovf & ~ovf_clr) | w_ovf_set;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_irq_pend_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_pend_arbiter
// Description : Directed self-checking bench for irq_pend_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_pend_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic       mask_wr;
    logic [3:0] mask_wdata;
    logic       out_valid;
    logic [1:0] out_idx;
    logic       out_ready;
    logic [3:0] pend;
`ifdef IRQ_PEND_OVERFLOW_EN
    logic [3:0] ovf;
    logic [3:0] ovf_clr;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    irq_pend_arbiter #(
        .N_SRC (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .mask_wr    (mask_wr),
        .mask_wdata (mask_wdata),
        .out_valid  (out_valid),
        .out_idx    (out_idx),
        .out_ready  (out_ready),
`ifdef IRQ_PEND_OVERFLOW_EN
        .ovf        (ovf),
        .ovf_clr    (ovf_clr),
`endif
        .pend       (pend)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [1:0] idx, input logic [3:0] p);
        chk({tag, ".valid"}, 32'(out_valid), 32'(v));
        if (v) chk({tag, ".idx"}, 32'(out_idx), 32'(idx));
        chk({tag, ".pend"}, 32'(pend), 32'(p));
    endtask

    initial begin
        reset = 1'b1; req = '0; mask_wr = 1'b0; mask_wdata = '0; out_ready = 1'b0;
`ifdef IRQ_PEND_OVERFLOW_EN
        ovf_clr = '0;
`endif
        step(); step();
        reset = 1'b0;
        chk_out("rst", 1'b0, 2'd0, 4'b0000);
        chk("rst.idx", 32'(out_idx), 32'd0);
        step();
        chk_out("idle", 1'b0, 2'd0, 4'b0000);

        // Single pulse on source 2
        req = 4'b0100; step();
        chk_out("t1.pend", 1'b0, 2'd0, 4'b0100);
        req = 4'b0000; step();
        chk_out("t1.grant", 1'b1, 2'd2, 4'b0100);
        out_ready = 1'b1; step();
        chk_out("t1.hs", 1'b0, 2'd0, 4'b0000);

        // Two simultaneous rises, ready held high
        req = 4'b1010; step();
        chk_out("t2.pend", 1'b0, 2'd0, 4'b1010);
        req = 4'b0000; step();
        chk_out("t2.g1", 1'b1, 2'd1, 4'b1010);
        step();
        chk_out("t2.bub", 1'b0, 2'd0, 4'b1000);
        step();
        chk_out("t2.g3", 1'b1, 2'd3, 4'b1000);
        step();
        chk_out("t2.end", 1'b0, 2'd0, 4'b0000);

        // Masked source 1
        mask_wr = 1'b1; mask_wdata = 4'b0010; step();
        mask_wr = 1'b0; req = 4'b1010; step();
        chk_out("t3.pend", 1'b0, 2'd0, 4'b1010);
        req = 4'b0000; step();
        chk_out("t3.g3", 1'b1, 2'd3, 4'b1010);
        step();
        chk_out("t3.hs", 1'b0, 2'd0, 4'b0010);
        step();
        chk_out("t3.held", 1'b0, 2'd0, 4'b0010);
        mask_wr = 1'b1; mask_wdata = 4'b0000; step();
        chk_out("t3.unm", 1'b0, 2'd0, 4'b0010);
        mask_wr = 1'b0; step();
        chk_out("t3.g1", 1'b1, 2'd1, 4'b0010);
        step();
        chk_out("t3.end", 1'b0, 2'd0, 4'b0000);
        out_ready = 1'b0;

        // Stall with ready low; masking must not retract the presented index
        req = 4'b0001; step();
        req = 4'b0000; step();
        chk_out("t4.g0", 1'b1, 2'd0, 4'b0001);
        mask_wr = 1'b1; mask_wdata = 4'b0001; req = 4'b0010; step();
        chk_out("t4.s1", 1'b1, 2'd0, 4'b0011);
        mask_wr = 1'b0; req = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_out("t4.stall", 1'b1, 2'd0, 4'b0011);
        end
        out_ready = 1'b1; step();
        chk_out("t4.hs", 1'b0, 2'd0, 4'b0010);
        step();
        chk_out("t4.g1", 1'b1, 2'd1, 4'b0010);
        step();
        chk_out("t4.end", 1'b0, 2'd0, 4'b0000);
        out_ready = 1'b0;
        mask_wr = 1'b1; mask_wdata = 4'b0000; step();
        mask_wr = 1'b0;

        // Re-rise on the same cycle as the clearing handshake
        req = 4'b0100; step();
        req = 4'b0000; step();
        chk_out("t5.g2", 1'b1, 2'd2, 4'b0100);
        out_ready = 1'b1; req = 4'b0100; step();
        chk_out("t5.keep", 1'b0, 2'd0, 4'b0100);
`ifdef IRQ_PEND_OVERFLOW_EN
        chk("t5.ovf", 32'(ovf), 32'd0);
`endif
        req = 4'b0000; step();
        chk_out("t5.regrant", 1'b1, 2'd2, 4'b0100);
        step();
        chk_out("t5.end", 1'b0, 2'd0, 4'b0000);
        out_ready = 1'b0;

        // Lost event on source 3, then reset while presenting
        req = 4'b1000; step();
        req = 4'b0000; step();
        chk_out("t6.g3", 1'b1, 2'd3, 4'b1000);
        req = 4'b1000; step();
        chk_out("t6.merge", 1'b1, 2'd3, 4'b1000);
`ifdef IRQ_PEND_OVERFLOW_EN
        chk("t6.ovf", 32'(ovf), 32'b1000);
        ovf_clr = 4'b1000;
`endif
        req = 4'b0000; step();
`ifdef IRQ_PEND_OVERFLOW_EN
        chk("t6.ovfclr", 32'(ovf), 32'd0);
        ovf_clr = 4'b0000;
`endif
        chk_out("t6.stall", 1'b1, 2'd3, 4'b1000);
        reset = 1'b1; step();
        chk_out("t6.rst", 1'b0, 2'd0, 4'b0000);
        chk("t6.rst.idx", 32'(out_idx), 32'd0);
`ifdef IRQ_PEND_OVERFLOW_EN
        chk("t6.rst.ovf", 32'(ovf), 32'd0);
`endif
        reset = 1'b0; step();
        chk_out("t6.post", 1'b0, 2'd0, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
